// File: rtl/fb_scanout.sv
// VGA 640x480@60 scan-out: 2x-doubled frame-buffer fetch, RGB332->444, bank swap at vblank entry.
// Latency: pixel addressed at (h,v) appears on vga_* RD_LAT+1 cycles later; free-running, no backpressure.
module fb_scanout #(
    parameter int RD_LAT = 2,
    parameter int FB_W   = 320,
    parameter int FB_H   = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fb_rd_en,
    output logic [16:0] fb_addr,
    output logic        fb_bank,
    input  logic [7:0]  fb_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        front_sel,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic        frame_start
);

    // Active area follows the frame buffer (2x doubling); porch/sync widths are the VGA 640x480 ones.
    localparam int H_ACT = 2 * FB_W;
    localparam int H_TOT = H_ACT + 16 + 96 + 48;
    localparam int V_ACT = 2 * FB_H;
    localparam int V_TOT = V_ACT + 10 + 2 + 33;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT_C = 10'(H_ACT);
    localparam logic [9:0] V_ACT_C = 10'(V_ACT);
    localparam logic [9:0] HS_BEG  = 10'(H_ACT + 16);
    localparam logic [9:0] HS_END  = 10'(H_ACT + 16 + 96);
    localparam logic [9:0] VS_BEG  = 10'(V_ACT + 10);
    localparam logic [9:0] VS_END  = 10'(V_ACT + 10 + 2);

    localparam logic [0:0] S_ACTIVE = 1'b0;
    localparam logic [0:0] S_VBLANK = 1'b1;

    // Pipeline word {frame_start, vsync_n, hsync_n, active}; idle keeps syncs deasserted.
    localparam logic [3:0] PIPE_IDLE = 4'b0110;

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [0:0]  state;
    logic [8:0]  px;
    logic [8:0]  py;
    logic [16:0] addr_full;
    logic        active;
    logic        hs_n;
    logic        vs_n;
    logic        fs;
    logic        vblank_entry;
    logic [3:0]  pipe [RD_LAT];
    logic [3:0]  aligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    assign px = hcount[9:1];
    assign py = vcount[9:1];

    generate
        if (FB_W == 320) begin : g_shift_add
            assign addr_full = 17'({py, 8'h00}) + 17'({py, 6'h00}) + 17'(px);
        end else begin : g_const_mul
            assign addr_full = 17'(int'(py) * FB_W + int'(px));
        end
    endgenerate

    assign active   = (hcount < H_ACT_C) && (vcount < V_ACT_C);
    assign hs_n     = !((hcount >= HS_BEG) && (hcount < HS_END));
    assign vs_n     = !((vcount >= VS_BEG) && (vcount < VS_END));
    assign fs       = (hcount == 10'd0) && (vcount == 10'd0);
    assign fb_rd_en = rst_n && active;
    assign fb_addr  = fb_rd_en ? addr_full : 17'd0;
    assign fb_bank  = front_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= PIPE_IDLE;
        end else begin
            pipe[0] <= {fs, vs_n, hs_n, active};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign aligned = pipe[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vde         <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
        end else begin
            vde         <= aligned[0];
            hsync       <= aligned[1];
            vsync       <= aligned[2];
            frame_start <= aligned[3];
            vga_r       <= aligned[0] ? {fb_data[7:5], fb_data[7]} : 4'h0;
            vga_g       <= aligned[0] ? {fb_data[4:2], fb_data[4]} : 4'h0;
            vga_b       <= aligned[0] ? {fb_data[1:0], fb_data[1:0]} : 4'h0;
        end
    end

    // state lags vcount by one cycle, so the ACTIVE->VBLANK edge is exactly (h=0, v=V_ACT).
    assign vblank_entry = (state == S_ACTIVE) && (vcount == V_ACT_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_ACTIVE;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            state    <= (vcount < V_ACT_C) ? S_ACTIVE : S_VBLANK;
            swap_ack <= vblank_entry && swap_req;
            if (vblank_entry && swap_req) front_sel <= ~front_sel;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboarded bench for fb_scanout on a reduced 32x24 frame buffer (VGA porches kept).
module tb_fb_scanout;
    localparam int L  = 2;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int HA = 2 * W;
    localparam int HT = HA + 160;
    localparam int VA = 2 * H;
    localparam int VT = VA + 45;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fb_rd_en;
    logic [16:0] fb_addr;
    logic        fb_bank;
    logic [7:0]  fb_data;
    logic        swap_req;
    logic        swap_ack;
    logic        front_sel;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, vde, frame_start;

    always #5 clk = ~clk;

    fb_scanout #(.RD_LAT(L), .FB_W(W), .FB_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_bank(fb_bank), .fb_data(fb_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .vde(vde), .frame_start(frame_start)
    );

    typedef struct {
        int   due;
        logic rd_en;
        logic [16:0] addr;
        logic bank;
        logic ack;
    } comb_t;

    typedef struct {
        int   due;
        logic vde, hs, vs, fs;
        logic [3:0] r, g, b;
    } out_t;

    comb_t cq[$];
    out_t  oq[$];
    logic [7:0] mem [2][W*H];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bank 0 holds addr[7:0] (0xE0/0x1C/0x03 present); bank 1 random so bank selection is visible.
    initial begin
        for (int a = 0; a < W*H; a++) begin
            mem[0][a] = 8'(a);
            mem[1][a] = 8'($urandom);
        end
    end

    // Frame-buffer memory: data for an address shows up RD_LAT cycles later, garbage when not read.
    initial begin : memdrv
        logic [18:0] hist[$];
        fb_data = 8'h00;
        forever begin
            @(negedge clk);
            hist.push_back({fb_rd_en, fb_bank, fb_addr});
            if (hist.size() > L + 1) void'(hist.pop_front());
            if (hist.size() == L + 1 && hist[0][18] === 1'b1)
                fb_data = mem[hist[0][17]][hist[0][15:0]];
            else
                fb_data = 8'($urandom);
        end
    end

    // Reference model: raster position is a cycle index since reset; outputs follow L+1 cycles later.
    initial begin : model
        int p, h, v, a;
        bit front, ack, act;
        logic [7:0] d8;
        out_t o;
        @(posedge clk);
        p = 0; front = 0; ack = 0;
        oq.push_back('{cyc, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0});
        forever begin
            @(negedge clk);
            #1;
            h = p % HT;
            v = p / HT;
            act = (h < HA) && (v < VA);
            a = act ? (v / 2) * W + h / 2 : 0;
            cq.push_back('{cyc, rst_n && act, (rst_n && act) ? 17'(a) : 17'd0, front, ack});
            if (!rst_n) begin
                while (oq.size() > 0 && oq[$].due > cyc) void'(oq.pop_back());
                for (int d = 1; d <= L + 1; d++)
                    oq.push_back('{cyc + d, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0});
                p = 0; front = 0; ack = 0;
            end else begin
                d8 = mem[front][a];
                o.due = cyc + L + 1;
                o.vde = act;
                o.hs  = !(h >= HA + 16 && h < HA + 112);
                o.vs  = !(v >= VA + 10 && v < VA + 12);
                o.fs  = (p == 0);
                o.r   = act ? 4'(d8[7:5] * 2 + d8[7:5] / 4) : 4'h0;
                o.g   = act ? 4'(d8[4:2] * 2 + d8[4:2] / 4) : 4'h0;
                o.b   = act ? 4'(d8[1:0] * 5) : 4'h0;
                oq.push_back(o);
                ack = (v == VA) && (h == 0) && (swap_req === 1'b1);
                if (ack) front = !front;
                p = (p + 1) % FR;
            end
        end
    end

    initial begin : monitor
        comb_t c;
        out_t  o;
        int last_fs = -1;
        forever begin
            @(negedge clk);
            #2;
            while (cq.size() > 0 && cq[0].due < cyc) begin
                chk("comb_stale", cq[0].due, cyc);
                void'(cq.pop_front());
            end
            if (cq.size() > 0 && cq[0].due == cyc) begin
                c = cq.pop_front();
                chk("fb_rd_en", fb_rd_en, c.rd_en);
                chk("fb_addr", fb_addr, c.addr);
                chk("fb_bank", fb_bank, c.bank);
                chk("front_sel", front_sel, c.bank);
                chk("swap_ack", swap_ack, c.ack);
            end
            while (oq.size() > 0 && oq[0].due < cyc) begin
                chk("out_stale", oq[0].due, cyc);
                void'(oq.pop_front());
            end
            if (oq.size() > 0 && oq[0].due == cyc) begin
                o = oq.pop_front();
                chk("vde", vde, o.vde);
                chk("hsync", hsync, o.hs);
                chk("vsync", vsync, o.vs);
                chk("frame_start", frame_start, o.fs);
                chk("vga_r", vga_r, o.r);
                chk("vga_g", vga_g, o.g);
                chk("vga_b", vga_b, o.b);
            end
            if (rst_n === 1'b0) last_fs = -1;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, FR);
                last_fs = cyc;
            end
        end
    end

    int k;

    task automatic spot();
        case (k)
            0:           chk("addr_v0", fb_addr, 0);
            HT:          chk("addr_v1", fb_addr, 0);
            2*HT:        chk("addr_v2", fb_addr, W);
            3*HT:        chk("addr_v3", fb_addr, W);
            (VA-1)*HT+HA-1: chk("addr_last", fb_addr, W*H-1);
            (VA-1)*HT+HA:   chk("rd_en_hblank", fb_rd_en, 0);
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        k++;
        spot();
    endtask

    initial begin : stim
        int budget;
        rst_n = 1'b0;
        swap_req = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
        swap_req = 1'b0;
        k = 0;
        spot();

        // Frame 0: request mid-frame, expect one ack just after vblank entry.
        while (k < 10 * HT) step();
        swap_req = 1'b1;
        budget = FR;
        while (swap_ack !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        chk("swap_ack_cycle", k, VA * HT + 1);
        swap_req = 1'b0;

        // Frame 1: random requests that never reach the evaluation line.
        while (k < 2 * FR) begin
            step();
            swap_req = ((k % FR) / HT < VA - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        swap_req = 1'b0;

        // Frame 2: request rises in the evaluation cycle itself.
        while (k < 2 * FR + VA * HT) step();
        swap_req = 1'b1;
        step();
        chk("swap_ack_same_cycle", swap_ack, 1);
        swap_req = 1'b0;

        // Frame 3: random requests, then reset mid-frame with a request pending.
        while (k < 3 * FR + 20 * HT + 150) begin
            step();
            swap_req = 1'($urandom_range(0, 1));
        end
        rst_n = 1'b0;
        swap_req = 1'b1;
        step();
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        step();
        rst_n = 1'b1;
        repeat (3 * HT) step();
        swap_req = 1'b0;
        repeat (L + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Video scan-out engine: the read side of the frame buffer that the rasterizer writes. It generates 640x480@60 VGA timing from a 25 MHz pixel clock and fetches the 320x240 8-bit (RGB 3-3-2) frame buffer with 2x pixel/line doubling. It expands each pixel to 12-bit RGB and outputs it aligned with the sync signals. It owns front/back bank selection and swaps banks at vertical blank on request from the rendering side.

## Interface
Parameters:
- RD_LAT, 2, frame-buffer read latency in cycles from address to data (1..4)
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in lines

Ports:
- clk  in  1  25.175/25 MHz pixel clock; the only clock
- rst_n  in  1  synchronous reset, active low
- fb_rd_en  out  1  frame-buffer read enable
- fb_addr  out  17  pixel address within bank, (y*320 + x)
- fb_bank  out  1  bank being read (front bank)
- fb_data  in  8  read data, valid RD_LAT cycles after address, {R[2:0],G[2:0],B[1:0]}
- swap_req  in  1  level; rendering side has finished the back bank
- swap_ack  out  1  one-cycle pulse; bank swap performed
- front_sel  out  1  current front bank; the rasterizer writes bank ~front_sel
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- hsync, vsync  out  1 each  active-low sync
- vde  out  1  active-video flag
- frame_start  out  1  one-cycle pulse on the first active pixel of each frame (output-aligned)

## Operation
- Counters: hcount 0..799, vcount 0..524. hcount increments every cycle and wraps 799->0. vcount increments on hcount wrap and wraps 524->0.
- Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Fetch stage, combinational on the counters:
  - fb_rd_en = (hcount<640 && vcount<480)
  - fb_addr = (vcount>>1)*320 + (hcount>>1), computed as (y<<8)+(y<<6)+x; no multiplier
  - fb_addr = 0 whenever fb_rd_en=0
- Address sequence per line: x,x pairs (0,0,1,1,...,319,319). Line pairs 2k and 2k+1 issue identical addresses.
- Alignment: the active/hsync/vsync/frame_start decode is delayed through an RD_LAT-deep shift register so it lines up with fb_data. Registered outputs then add one further stage.
- Colour expansion:
  - vga_r = {R,R[2]}, vga_g = {G,G[2]}, vga_b = {B,B}
  - all 0 when the aligned active flag is 0
- Bank swap:
  - Evaluated in the single cycle hcount=0, vcount=480, i.e. the first blanking line.
  - If swap_req=1 in that cycle: front_sel toggles and swap_ack pulses in the following cycle.
  - If swap_req=0: no action.
  - swap_req high at any other time waits for the next evaluation point.
  - The requester must drop swap_req after swap_ack. If it is still high at the next vblank evaluation, a second swap occurs (defined behaviour).
- fb_bank = front_sel; it changes only during vertical blank, never mid-frame.
- States: ACTIVE (vcount<480) and VBLANK. The swap can occur only on the ACTIVE->VBLANK transition.

## Timing
- Reset values (rst_n=0 at a clk edge):
  - hcount=0, vcount=0, alignment pipeline cleared
  - fb_rd_en=0, fb_addr=0, front_sel=0, fb_bank=0, swap_ack=0
  - hsync=1, vsync=1, vde=0, frame_start=0, RGB=0
- Reset mid-frame: all of the above take effect on the next edge; a pending swap_req is not honoured until the next evaluation point after reset release.
- First cycle after reset release: hcount=0, vcount=0, fb_rd_en=1, fb_addr=0.
- Output latency: the pixel addressed at counter (h,v) appears on vga_* with vde=1 exactly RD_LAT+1 cycles later.
- hsync, vsync and vde carry the same RD_LAT+1 delay, so sync-to-pixel relationships match standard timing at the output.
- frame_start: asserted for exactly one cycle per 420000 cycles, coincident with the first vde=1 of the frame.
- Simultaneous swap_req rising and the evaluation cycle: the swap is honoured.
- Wrap-around: h=799,v=524 -> h=0,v=0 with no idle cycle.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with swap_req=1 -> all outputs at reset values, no swap_ack; after release fb_addr sequence is 0,0,1,1,2,2 with fb_rd_en=1.
- Line doubling: sample fb_addr at h=0 on v=0,1,2,3 -> 0, 0, 320, 320. At h=639,v=479 -> 76799. fb_rd_en=0 at h=640.
- Sync timing (RD_LAT=2): hsync low for output cycles corresponding to h=656..751 (96 cycles), vsync low for 2 lines (1600 cycles), frame period 420000 cycles between frame_start pulses.
- Colour/alignment: model returns fb_data=addr[7:0] with latency 2. fb_data 8'hE0 -> RGB F/0/0, 8'h1C -> 0/F/0, 8'h03 -> 0/0/F. First vde pixel equals address 0 data; RGB=0 during blank.
- Swap: raise swap_req at v=100 -> swap_ack single pulse at cycle after (h=0,v=480), front_sel 0->1, fb_bank stable through the whole active region. Drop swap_req after ack -> no swap at next vblank.
- Mid-frame reset at h=300,v=200 -> counters restart at 0,0 on next edge, hsync/vsync=1, front_sel=0.
